// File: rtl/neo_palette_out.sv
// Palette RAM and colour output stage: 8K x 16 palette lookup, two-stage pixel
// pipeline with dark/shadow/blank, plus a 68K read/write port sharing the PA bus.
module neo_palette_out (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        CLK_EN_6MB,
  input  logic [11:0] PA,
  input  logic        PALBNK,
  input  logic        BNKB,
  input  logic        SHADOW,
  input  logic        nPAL_CS,
  input  logic        RW,
  input  logic        nUDS,
  input  logic        nLDS,
  input  logic [15:0] CPU_DIN,
  output logic [15:0] CPU_DOUT,
  output logic        PAL_RDY,
  output logic [5:0]  R,
  output logic [5:0]  G,
  output logic [5:0]  B
);

  typedef enum logic [2:0] {IDLE, ARM, WR, RD1, RD2, DONE} state_t;

  state_t      state;
  logic [15:0] mem [0:8191];
  logic [15:0] ram_q;
  logic [12:0] addr;
  logic        wr_cycle;

  logic [15:0] col_a;
  logic        blk_a;
  logic        shd_a;
  logic [5:0]  r_n, g_n, b_n;

  assign addr     = {PALBNK, PA};
  assign wr_cycle = (state == WR);

  // NOTE: the palette array has no reset so it maps onto block RAM; only the
  // read register and control state are cleared by nRST.
  always_ff @(posedge CLK) begin
    if (wr_cycle) begin
      if (!nUDS) mem[addr][15:8] <= CPU_DIN[15:8];
      if (!nLDS) mem[addr][7:0]  <= CPU_DIN[7:0];
    end
  end

  // Read port holds during a write so a colliding pixel keeps the old colour.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ram_q <= '0;
    end else if (!wr_cycle) begin
      ram_q <= mem[addr];
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      PAL_RDY  <= 1'b0;
      CPU_DOUT <= '0;
    end else begin
      case (state)
        IDLE: if (!nPAL_CS) state <= ARM;
        ARM: begin
          // PA mux upstream has had one CLK to switch to the CPU address.
          if (nPAL_CS)  state <= IDLE;
          else if (RW)  state <= RD1;
          else          state <= WR;
        end
        WR: begin
          state   <= DONE;
          PAL_RDY <= 1'b1;
        end
        RD1: state <= RD2;
        RD2: begin
          CPU_DOUT <= ram_q;
          state    <= DONE;
          PAL_RDY  <= 1'b1;
        end
        DONE: begin
          if (nPAL_CS) begin
            state   <= IDLE;
            PAL_RDY <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          PAL_RDY <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    r_n = {col_a[11:8], col_a[14], ~col_a[15]};
    g_n = {col_a[7:4],  col_a[13], ~col_a[15]};
    b_n = {col_a[3:0],  col_a[12], ~col_a[15]};
    if (shd_a) begin
      r_n = r_n >> 1;
      g_n = g_n >> 1;
      b_n = b_n >> 1;
    end
    if (!blk_a) begin
      r_n = '0;
      g_n = '0;
      b_n = '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      col_a <= '0;
      blk_a <= 1'b0;
      shd_a <= 1'b0;
      R     <= '0;
      G     <= '0;
      B     <= '0;
    end else if (CLK_EN_6MB) begin
      col_a <= ram_q;
      blk_a <= BNKB;
      shd_a <= SHADOW;
      R     <= r_n;
      G     <= g_n;
      B     <= b_n;
    end
  end

endmodule

// File: doc/neo_palette_out.md
# neo_palette_out

Palette RAM and colour-output stage directly downstream of the palette-address generator. Takes the 12-bit palette address bus PA plus the palette bank bit, looks the colour word up in an internal 8K×16 palette RAM, and produces registered 6-bit-per-channel RGB, with dark-bit, shadow and blanking applied. It also services 68K palette reads and writes, whose address arrives over the same PA bus during CPU access cycles.

## Interface
- No parameters.
- CLK  in  1  system clock; all logic on posedge
- nRST  in  1  asynchronous active-low reset
- CLK_EN_6MB  in  1  pixel clock enable, one CLK wide
- PA  in  12  palette address (video or CPU, muxed upstream)
- PALBNK  in  1  palette bank select; RAM address = {PALBNK, PA}
- BNKB  in  1  active-low video blank
- SHADOW  in  1  shadow mode (halves intensity)
- nPAL_CS  in  1  CPU palette chip select, active low
- RW  in  1  CPU read(1)/write(0)
- nUDS, nLDS  in  1 each  CPU byte strobes, active low
- CPU_DIN  in  16  CPU write data
- CPU_DOUT  out  16  CPU read data, held until next read
- PAL_RDY  out  1  access complete (DTACK source), high until nPAL_CS rises
- R, G, B  out  6 each  colour output

## Operation
- The RAM is single-port, 8192×16 words, with synchronous read. Every CLK it reads {PALBNK, PA} into RAM_Q, except on a write cycle. On a write cycle it writes, and RAM_Q holds its previous value.
- Contents are not reset.
- Colour word c: D15 = dark, D14/13/12 = R0/G0/B0, D11:8 = R4:1, D7:4 = G4:1, D3:0 = B4:1.
- Each 6-bit channel is {4-bit field, LSB bit, ~c[15]}. Example: R = {c[11:8], c[14], ~c[15]}.
- With SHADOW = 1, every channel is shifted right by one, zero-filled.
- With the sampled BNKB = 0, R, G and B are forced to 0.
- CPU FSM states are IDLE, ARM, WR, RD1, RD2, DONE:
  - IDLE → ARM when nPAL_CS is sampled low. ARM waits one CLK so the upstream PA mux has settled.
  - ARM → IDLE if nPAL_CS has risen. Otherwise ARM → WR when RW = 0, or ARM → RD1 when RW = 1.
  - WR: one-CLK RAM write with byte enables. nUDS low writes [15:8]; nLDS low writes [7:0]; both high writes nothing but the cycle still completes. Then → DONE.
  - RD1: the address is applied. RD2: CPU_DOUT <= RAM_Q. Then → DONE.
  - DONE: PAL_RDY = 1. → IDLE when nPAL_CS is sampled high.
- Only one RAM write occurs per CPU access, however long nPAL_CS stays low.
- The video pipeline keeps running during CPU access. Pixels show whatever address PA carries; this matches the hardware artefact.

## Timing
- Reset values: R = G = B = 0, CPU_DOUT = 0, PAL_RDY = 0, FSM in IDLE, all pipeline registers 0.
- Stage A, on CLK_EN_6MB: COL_A <= RAM_Q, BLK_A <= BNKB, SHD_A <= SHADOW.
- Stage B, on the next CLK_EN_6MB: R/G/B <= f(COL_A, SHD_A, BLK_A).
- Latency: PA is stable at least 1 CLK before enable N, and its colour appears on R/G/B after enable N+1. BNKB and SHADOW sampled at enable N align with that same pixel.
- CPU write: PAL_RDY rises 3 CLKs after the first CLK with nPAL_CS sampled low (IDLE→ARM→WR→DONE). The written data is visible in RAM_Q 1 CLK after the WR state.
- CPU read: PAL_RDY and CPU_DOUT are valid 4 CLKs after the first CLK with nPAL_CS sampled low.
- If a WR cycle coincides with CLK_EN_6MB, stage A captures the held RAM_Q. A video read of the same address therefore returns the old data.
- nRST asserted mid-access: the FSM goes to IDLE at once and PAL_RDY drops. A write is either completed or not started; it is never partial.
- A second access requires nPAL_CS to return high first. Back-to-back accesses therefore need at least 1 CLK of nPAL_CS high.

## Test plan
- Reset: hold nRST low with random inputs → R/G/B = 0, PAL_RDY = 0, CPU_DOUT = 0. Release it → no change until the second CLK_EN_6MB.
- CPU write then read: PALBNK = 0, PA = 12'h123, write 16'h7FFF with both strobes → PAL_RDY high after 3 CLKs. A read of the same address → CPU_DOUT = 16'h7FFF after 4 CLKs.
- Byte lanes: preload 16'h0000, write 16'hABCD with only nLDS low → readback is 16'h00CD.
- Colour path: word 16'h7FFF, BNKB = 1, SHADOW = 0 → R = G = B = 6'h3F two enables later. Word 16'h8F00 → R = 6'h3C, G = B = 6'h00. With SHADOW = 1 and 16'h7FFF → 6'h1F.
- Blank and bank: BNKB = 0 → outputs 0 with the same two-enable latency. Bank 1 and bank 0 at the same PA hold distinct words, and toggling PALBNK switches the output.
- Collision and mid-access reset:
  - A write coinciding with CLK_EN_6MB at the displayed address → that pixel shows the old colour, and the next pixel shows the new one.
  - nRST pulsed while in the RD1 state → IDLE, PAL_RDY = 0, RAM unchanged.
